// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the multi-digit 7-segment hex display driver.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns indexed by nibble value, bit 0 = segment a.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int unsigned blink_half(int unsigned clk_hz, int unsigned blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_PATTERNS[nibble];

endmodule

// File: rtl/hex_display_driver.sv
// Captures a hex value and drives NUM_DIGITS registered active-low 7-segment digits
// with leading-zero blanking, per-digit enables and whole-display blinking.
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    hold,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [7*NUM_DIGITS-1:0] segments,
  output logic                    loaded
);

  localparam int unsigned HALF = blink_half(CLK_HZ, BLINK_HZ);
  localparam int unsigned CW = $clog2(HALF);
  localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

  logic [4*NUM_DIGITS-1:0] value_q;
  logic                    loaded_q;
  logic [CW-1:0]           blink_cnt_d, blink_cnt_q;
  logic                    phase_d, phase_q;
  logic                    capture;
  logic                    blank_all;

  assign capture = load & ~hold;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q  <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (capture) begin
        value_q <= value;
      end
      loaded_q <= capture;
    end
  end

  assign loaded = loaded_q;

  // Disabled blink parks the counter so every enable begins with a full visible phase.
  always_comb begin
    blink_cnt_d = '0;
    phase_d     = 1'b0;
    if (blink_en) begin
      if (blink_cnt_q == CNT_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blank_all = blink_en & phase_q;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [6:0] enc;
    logic [6:0] seg_d;
    logic [6:0] seg_q;
    logic       lz_blank;

    seg7_encode u_enc (
      .nibble (value_q[4*i +: 4]),
      .seg    (enc)
    );

    if (i == 0) begin : g_lsd
      assign lz_blank = 1'b0;
    end else begin : g_upper
      // Uses value_q regardless of digit_en so disabled nonzero digits still stop blanking.
      assign lz_blank = blank_lz & ~(|value_q[4*NUM_DIGITS-1 : 4*i]);
    end

    always_comb begin
      seg_d = enc;
      if (blank_all || !digit_en[i] || lz_blank) begin
        seg_d = SEG_BLANK;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        seg_q <= SEG_BLANK;
      end else begin
        seg_q <= seg_d;
      end
    end

    assign segments[7*i +: 7] = seg_q;
  end

endmodule

// File: tb/tb_hex_display_driver.sv
// Randomized and directed self-checking bench for hex_display_driver (6 digits, HALF=4).
module tb_hex_display_driver;

  localparam int ND   = 6;
  localparam int HALF = 4;

  logic          clk;
  logic          reset_n;
  logic [23:0]   value;
  logic          load;
  logic          hold;
  logic          blank_lz;
  logic          blink_en;
  logic [5:0]    digit_en;
  logic [41:0]   segments;
  logic          loaded;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  hex_display_driver #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (8),
    .BLINK_HZ   (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .hold     (hold),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .digit_en (digit_en),
    .segments (segments),
    .loaded   (loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference display: what the rules say should be shown for a held value and controls.
  function automatic logic [41:0] model_segs(logic [23:0] v, logic blz, logic [5:0] den,
                                             logic blank_all);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      logic [6:0] d;
      int unsigned upper;
      upper = 32'(v) >> (4 * i);
      if (blank_all)                         d = 7'h7F;
      else if (!den[i])                      d = 7'h7F;
      else if (blz && i > 0 && upper == 0)   d = 7'h7F;
      else                                   d = seg_tab[(32'(v) >> (4 * i)) % 16];
      r[7*i +: 7] = d;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; value = '0; load = 0; hold = 0; blank_lz = 0; blink_en = 0;
    digit_en = 6'h3F;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (segments !== {6{7'h7F}}) begin
      errors++; $display("FAIL reset_segments: got %h expected %h", segments, {6{7'h7F}});
    end
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("FAIL reset_loaded: got %b expected 0", loaded);
    end
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (segments !== {6{7'h40}}) begin
      errors++; $display("FAIL reset_first_edge: got %h expected %h", segments, {6{7'h40}});
    end
  endtask

  task automatic test_load_basic();
    value = 24'h00ABCD; load = 1; blank_lz = 0; digit_en = 6'h3F;
    tick();
    load = 0;
    checks++;
    if (loaded !== 1'b1) begin
      errors++; $display("FAIL load_pulse: got %b expected 1", loaded);
    end
    checks++;
    if (segments !== {6{7'h40}}) begin
      errors++; $display("FAIL load_latency1: got %h expected %h", segments, {6{7'h40}});
    end
    tick();
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("FAIL load_pulse_width: got %b expected 0", loaded);
    end
    checks++;
    if (segments !== {7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21}) begin
      errors++; $display("FAIL load_abcd: got %h expected %h", segments,
                         {7'h40, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21});
    end
  endtask

  task automatic test_lz();
    blank_lz = 1;
    tick();
    checks++;
    if (segments !== {7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21}) begin
      errors++; $display("FAIL lz_abcd: got %h expected %h", segments,
                         {7'h7F, 7'h7F, 7'h08, 7'h03, 7'h46, 7'h21});
    end
    value = 24'h000000; load = 1;
    tick();
    load = 0;
    tick();
    checks++;
    if (segments !== {{5{7'h7F}}, 7'h40}) begin
      errors++; $display("FAIL lz_zero: got %h expected %h", segments, {{5{7'h7F}}, 7'h40});
    end
  endtask

  task automatic test_hold();
    blank_lz = 0; hold = 1; value = 24'h123456; load = 1;
    tick();
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("FAIL hold_no_pulse: got %b expected 0", loaded);
    end
    load = 0;
    tick();
    checks++;
    if (segments !== {6{7'h40}}) begin
      errors++; $display("FAIL hold_unchanged: got %h expected %h", segments, {6{7'h40}});
    end
    hold = 0; load = 1;
    tick();
    load = 0;
    checks++;
    if (loaded !== 1'b1) begin
      errors++; $display("FAIL hold_release_pulse: got %b expected 1", loaded);
    end
    tick();
    checks++;
    if (segments !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
      errors++; $display("FAIL hold_release_capture: got %h expected %h", segments,
                         {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    end
  endtask

  task automatic test_blink();
    logic [41:0] vis;
    logic [41:0] exp;
    vis = model_segs(24'h123456, 1'b0, 6'h3F, 1'b0);
    blink_en = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp = (((k / HALF) % 2) == 1) ? {6{7'h7F}} : vis;
      checks++;
      if (segments !== exp) begin
        errors++; $display("FAIL blink_cycle%0d: got %h expected %h", k, segments, exp);
      end
    end
    blink_en = 0;
    tick();
    checks++;
    if (segments !== vis) begin
      errors++; $display("FAIL blink_off: got %h expected %h", segments, vis);
    end
  endtask

  task automatic test_digit_en();
    value = 24'h000010; load = 1; blank_lz = 1; digit_en = 6'h3E;
    tick();
    load = 0;
    tick();
    checks++;
    if (segments !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F}) begin
      errors++; $display("FAIL digit_en_3e: got %h expected %h", segments,
                         {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h7F});
    end
    // Disabled nonzero digit must still stop leading-zero blanking below it.
    value = 24'h300001; load = 1; digit_en = 6'h1F;
    tick();
    load = 0;
    tick();
    checks++;
    if (segments !== {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}) begin
      errors++; $display("FAIL digit_en_lz_stop: got %h expected %h", segments,
                         {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79});
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vals [3];
    logic [41:0] exp;
    vals[0] = 24'hFEDCBA; vals[1] = 24'h987654; vals[2] = 24'h0A0B0C;
    blank_lz = 0; digit_en = 6'h3F; hold = 0;
    for (int k = 0; k < 4; k++) begin
      load = (k < 3);
      if (k < 3) value = vals[k];
      tick();
      checks++;
      if (loaded !== (k < 3)) begin
        errors++; $display("FAIL b2b_pulse%0d: got %b expected %b", k, loaded, (k < 3));
      end
      if (k > 0) begin
        exp = model_segs(vals[k-1], 1'b0, 6'h3F, 1'b0);
        checks++;
        if (segments !== exp) begin
          errors++; $display("FAIL b2b_segs%0d: got %h expected %h", k, segments, exp);
        end
      end
    end
    load = 0;
  endtask

  task automatic test_async_reset();
    value = 24'h123456; load = 1; blank_lz = 0; digit_en = 6'h3F; hold = 0;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (segments !== {6{7'h7F}}) begin
      errors++; $display("FAIL async_reset_segs: got %h expected %h", segments, {6{7'h7F}});
    end
    #1 reset_n = 1'b1;
    load = 0;
    tick();
    checks++;
    if (loaded !== 1'b0) begin
      errors++; $display("FAIL async_reset_no_pulse: got %b expected 0", loaded);
    end
    checks++;
    if (segments !== {6{7'h40}}) begin
      errors++; $display("FAIL async_reset_value0: got %h expected %h", segments, {6{7'h40}});
    end
  endtask

  // Model: held value plus count of consecutive blink-enabled edges.
  task automatic test_random();
    logic [23:0] mv;
    int          en_k;
    logic [41:0] exp_seg;
    logic        exp_ld;
    mv = 24'h0; en_k = 0; blink_en = 0;
    for (int n = 0; n < 400; n++) begin
      value    = 24'(($urandom >> $urandom_range(0, 31)) & 32'hFFFFFF);
      load     = ($urandom_range(0, 2) == 0);
      hold     = ($urandom_range(0, 3) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      digit_en = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
      if ($urandom_range(0, 19) == 0) blink_en = ~blink_en;
      exp_seg = model_segs(mv, blank_lz, digit_en, blink_en && (((en_k / HALF) % 2) == 1));
      exp_ld  = load && !hold;
      if (exp_ld) mv = value;
      en_k = blink_en ? en_k + 1 : 0;
      tick();
      checks++;
      if (segments !== exp_seg) begin
        errors++; $display("FAIL rand_segs%0d: got %h expected %h", n, segments, exp_seg);
      end
      checks++;
      if (loaded !== exp_ld) begin
        errors++; $display("FAIL rand_loaded%0d: got %b expected %b", n, loaded, exp_ld);
      end
    end
    load = 0; hold = 0; blink_en = 0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_lz();
    test_hold();
    test_blink();
    test_digit_en();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
